// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional odd parity, one stop bit.
// Bit timing is derived from the shared oversampling strobe tick_16x.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_enable,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(OVS_FACTOR);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS_FACTOR - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 tx_pin_q;
  logic                 tx_done_q;
  logic                 bit_end;

  assign bit_end = tick_16x && (cnt_q == CNT_LAST);
  assign shift_d = shift_q >> 1;

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_pin   = tx_pin_q;
  assign tx_done  = tx_done_q;

  // tx_pin_q is loaded with the level of the state being entered, so the line
  // changes in the same cycle as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_pin_q  <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (state_q != IDLE && tick_16x) begin
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_q   <= tx_data;
            par_en_q  <= parity_enable;
            // Parity is taken from the whole word now, before it is shifted out.
            par_bit_q <= ~^tx_data;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_pin_q  <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_pin_q <= shift_q[0];
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_d;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              if (par_en_q) begin
                tx_pin_q <= par_bit_q;
                state_q  <= PARITY;
              end else begin
                tx_pin_q <= 1'b1;
                state_q  <= STOP;
              end
            end else begin
              tx_pin_q <= shift_d[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_pin_q <= 1'b1;
            state_q  <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_pin_q  <= 1'b1;
            tx_done_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          tx_pin_q <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule
